// File: rtl/multiplier_pkg.sv
// multiplier_pkg: shared widths, iteration count and FSM encoding for the multiplier.
// Contents: MUL_WIDTH (operand width), MUL_ITERS (shift-add iterations per product),
//           CNT_W (iteration counter width), state_t (IDLE/BUSY/DONE).
package multiplier_pkg;
   localparam int MUL_WIDTH = 32;
   localparam int MUL_ITERS = 32;
   localparam int CNT_W     = 6;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/multiplier.sv
// multiplier: iterative radix-2 shift-add multiplier, signed or unsigned, one bit per cycle.
// Ports: clk       - rising-edge clock
//        rst_n     - synchronous active-low reset
//        sign      - 1 = two's-complement operands, 0 = unsigned
//        enable    - high runs/holds an operation, low aborts and idles
//        multi_1   - multiplicand
//        multi_2   - multiplier
//        product   - registered 2*WIDTH-bit result, holds last completed value
//        multready - registered, high while product is valid for the current operation
module multiplier
   import multiplier_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sign,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     multi_1,
   input  logic [WIDTH-1:0]     multi_2,
   output logic [2*WIDTH-1:0]   product,
   output logic                 multready
);
   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc, r_a, w_sum, w_a_ext;
   logic [WIDTH-1:0]   r_b, w_a_mag, w_b_mag;
   logic               r_neg, w_last, w_start;

   // Signed operands are reduced to magnitudes; the most negative value negates to
   // itself, which read unsigned is exactly 2^(WIDTH-1).
   always_comb begin
      w_a_mag     = (sign && multi_1[WIDTH-1]) ? -multi_1 : multi_1;
      w_b_mag     = (sign && multi_2[WIDTH-1]) ? -multi_2 : multi_2;
      w_a_ext     = {{WIDTH{1'b0}}, w_a_mag};
      w_sum       = r_acc + (r_b[0] ? r_a : '0);
      w_start     = r_state == IDLE && enable;
      w_last      = r_state == BUSY && r_cnt == CNT_W'(MUL_ITERS - 1);
      w_state_nxt = !enable ? IDLE : w_start ? BUSY : w_last ? DONE : r_state;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // The start edge already consumes multiplier bit 0, so BUSY runs the remaining
   // iterations and the counter reaches MUL_ITERS-1 on the final one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         product   <= '0;
         multready <= 1'b0;
         r_acc     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_neg     <= 1'b0;
         r_cnt     <= '0;
      end else begin
         multready <= w_state_nxt == DONE;
         if (w_start) begin
            r_acc <= w_b_mag[0] ? w_a_ext : '0;
            r_a   <= w_a_ext << 1;
            r_b   <= w_b_mag >> 1;
            r_neg <= sign & (multi_1[WIDTH-1] ^ multi_2[WIDTH-1]);
            r_cnt <= CNT_W'(1);
         end else if (r_state == BUSY && enable) begin
            r_acc <= w_sum;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) product <= r_neg ? -w_sum : w_sum;
         end
      end
   end
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: table-driven scoreboard bench for multiplier, plus abort/reset/hold sequences.
module tb_multiplier;
   logic        clk = 1'b0;
   logic        rst_n, sign, enable;
   logic [31:0] multi_1, multi_2;
   logic [63:0] product;
   logic        multready;

   typedef struct {
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   localparam int NV = 17;
   vec_t        vt[NV];
   logic [63:0] sb[$];
   logic [63:0] last_prod;
   int          n_pass = 0;
   int          n_tot  = 0;

   multiplier dut (
      .clk(clk), .rst_n(rst_n), .sign(sign), .enable(enable),
      .multi_1(multi_1), .multi_2(multi_2), .product(product), .multready(multready)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] model(logic s, logic [31:0] a, logic [31:0] b);
      if (s) return 64'($signed(a)) * 64'($signed(b));
      return {32'b0, a} * {32'b0, b};
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   // One full operation: idle one edge, start, scramble operands after the start edge,
   // expect multready low through edge 31 and high with the scoreboard value at edge 32.
   task automatic run_op(vec_t v);
      logic early;
      logic [63:0] exp;
      early = 1'b0;
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      sign = v.s; multi_1 = v.a; multi_2 = v.b; enable = 1'b1;
      sb.push_back(v.exp);
      for (int e = 1; e <= 32; e++) begin
         @(posedge clk);
         #1;
         if (e == 1) begin
            multi_1 = $urandom; multi_2 = $urandom; sign = ~v.s;
         end
         if (e < 32 && multready) early = 1'b1;
      end
      chk("early_ready", {63'b0, early}, 64'd0);
      chk("ready_at_32", {63'b0, multready}, 64'd1);
      exp = sb.pop_front();
      chk("product", product, exp);
      last_prod = exp;
   endtask

   initial begin
      vt[0]  = '{1'b0, 32'd3,         32'd2,         64'd6};
      vt[1]  = '{1'b1, 32'd0,         32'h80,        64'd0};
      vt[2]  = '{1'b1, 32'hFFFFFFFF,  32'd0,         64'd0};
      vt[3]  = '{1'b1, 32'hFFFFFFF8,  32'd2,         64'hFFFFFFFFFFFFFFF0};
      vt[4]  = '{1'b1, 32'd2,         32'hFFFFFFF8,  64'hFFFFFFFFFFFFFFF0};
      vt[5]  = '{1'b1, 32'hFFFFFFF2,  32'hFFFFFFF8,  64'h70};
      vt[6]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE00000001};
      vt[7]  = '{1'b1, 32'h80000000,  32'h80000000,  64'h4000000000000000};
      vt[8]  = '{1'b0, 32'h80000000,  32'h80000000,  64'h4000000000000000};
      vt[9]  = '{1'b1, 32'h80000000,  32'd1,         64'hFFFFFFFF80000000};
      vt[10] = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'd1};
      for (int i = 11; i < NV; i++) begin
         vt[i].s = i[0];
         vt[i].a = $urandom;
         vt[i].b = $urandom;
         vt[i].exp = model(vt[i].s, vt[i].a, vt[i].b);
      end

      rst_n = 1'b0; enable = 1'b0; sign = 1'b0; multi_1 = '0; multi_2 = '0;
      last_prod = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_product", product, 64'd0);
      chk("reset_ready", {63'b0, multready}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_op(vt[i]);

      // Hold in DONE with enable high while operands change: nothing may move.
      multi_1 = 32'd5; multi_2 = 32'd7; sign = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_product", product, last_prod);
         chk("hold_ready", {63'b0, multready}, 64'd1);
      end

      // Abort: enable sampled low at edge 10; no result may ever appear.
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      multi_1 = 32'd7; multi_2 = 32'd9; enable = 1'b1;
      repeat (9) @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_ready", {63'b0, multready}, 64'd0);
      begin
         logic bad;
         bad = 1'b0;
         repeat (35) begin
            @(posedge clk);
            #1;
            if (multready || product !== last_prod) bad = 1'b1;
         end
         chk("abort_no_result", {63'b0, bad}, 64'd0);
      end

      // Reset mid-run clears outputs, then a fresh operation completes normally.
      @(negedge clk);
      multi_1 = 32'd11; multi_2 = 32'd13; enable = 1'b1;
      repeat (15) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; enable = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_product", product, 64'd0);
      chk("midrst_ready", {63'b0, multready}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op('{1'b1, 32'hFFFFFFF5, 32'd1000, model(1'b1, 32'hFFFFFFF5, 32'd1000)});
      run_op('{1'b0, 32'h12345678, 32'h9ABCDEF0, model(1'b0, 32'h12345678, 32'h9ABCDEF0)});

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter WIDTH, default 32, operand width; product width is 2*WIDTH.
REQ-003 Port clk, input, 1, rising-edge clock for all state.
REQ-004 Port rst_n, input, 1, synchronous active-low reset.
REQ-005 Port sign, input, 1, 1 = two's-complement operands, 0 = unsigned.
REQ-006 Port enable, input, 1, high = run/hold an operation; low = abort and idle.
REQ-007 Port multi_1, input, 32, multiplicand.
REQ-008 Port multi_2, input, 32, multiplier.
REQ-009 Port product, output, 64, registered result.
REQ-010 Port multready, output, 1, registered; high = product valid for the current operation.

Function
REQ-011 The block SHALL be an iterative radix-2 shift-add multiplier with states IDLE, BUSY and DONE.
REQ-012 IDLE: on a rising edge with enable=1, the block SHALL latch multi_1, multi_2 and sign, perform iteration 1, and go to BUSY.
REQ-013 Operand and sign changes after the start edge SHALL be ignored until the next start.
REQ-014 For sign=1, the block SHALL multiply operand magnitudes (|x|, with 0x80000000 treated as 2^31) and negate the 64-bit result when the operand sign bits differ.
REQ-015 For sign=0, the block SHALL compute the plain unsigned 32x32->64 product.
REQ-016 BUSY SHALL perform one iteration per cycle, 32 iterations in total, the start edge counting as iteration 1.
REQ-017 On the edge of iteration 32, product SHALL load the final 64-bit result, multready SHALL go to 1, and the state SHALL go to DONE; multready is therefore high after 32 rising edges from the start edge.
REQ-018 DONE with enable=1: product and multready SHALL hold and no new operation SHALL start.
REQ-019 enable=0 in any state: on the next edge the state SHALL become IDLE and multready 0; an in-flight computation is discarded.
REQ-020 product SHALL hold its last completed value until the next completion or reset.
REQ-021 A new operation SHALL require enable to be low for at least one edge and then high.
REQ-022 multready SHALL never be high while the state is IDLE or BUSY.
REQ-023 Results SHALL be exact for all operand values, including 0, 0xFFFFFFFF and 0x80000000 in both sign modes.

Reset
REQ-024 When rst_n=0 on a rising edge, the block SHALL set state IDLE, product 64'h0 and multready 0, with priority over enable.
REQ-025 Reset mid-operation SHALL abort the operation; a new start requires rst_n=1 and enable sampled high.

Structure
REQ-026 A shared package SHALL hold WIDTH=32, the iteration count 32, the IDLE/BUSY/DONE state encoding and the iteration counter width (6 bits).
REQ-027 The block SHALL be implemented as one module with no sub-module; magnitude/negate logic is inline combinational logic.

Verification
REQ-028 sign=0, 3 x 2 -> after 32 edges: product=6, multready=1; multready=0 at every earlier edge.
REQ-029 sign=1 zero cases: 0 x 80 -> 0; 0xFFFFFFFF x 0 -> 0.
REQ-030 sign=1 mixed signs: 0xFFFFFFF8 x 2 -> 0xFFFFFFFFFFFFFFF0; 2 x 0xFFFFFFF8 -> 0xFFFFFFFFFFFFFFF0.
REQ-031 sign=1, 0xFFFFFFF2 x 0xFFFFFFF8 -> 0x70; sign=0, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001.
REQ-032 Abort and reset: enable dropped at edge 10 of a run -> multready=0 and the result is never produced; rst_n=0 mid-run -> product=0, multready=0.
REQ-033 Hold and restart: enable held high in DONE for 5 cycles -> outputs stable; enable toggled low/high with new operands -> new result after 32 edges.
